// File: rtl/neuron_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// neuron_cfg_sequencer
//
// Host-side sequencer for the neuron array (top_neurons). The host loads a
// configuration image into a local buffer: four words per neuron, in the order
// Vmem, Mu, NeuronI, Q. A start pulse then drives the array's ins bus with the
// active-neuron count, the BEGIN_WR marker (all ones) and the buffered words,
// each held for WORD_HOLD cycles. The sequencer waits for the programmed number
// of anneal cycles, pulses rd, and forwards the readout words until the array
// raises readDone or a timeout expires.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   host_wr_*       valid/ready write port into the configuration buffer
//   clear           empties the buffer (IDLE only)
//   start           begins a sequence (IDLE only); samples num_active and
//                   anneal_cycles
//   ins             word stream to the array
//   rd              one-cycle readout request to the array
//   outs, readDone  readout word and last-word flag from the array
//   rd_data/valid   captured readout word, one-cycle valid, no backpressure
//   busy            sequence in progress (state != IDLE)
//   err             one-cycle pulse: rejected start or readout timeout
// -----------------------------------------------------------------------------
module neuron_cfg_sequencer #(
    parameter int FP_DATA_WIDTH   = 16,
    parameter int NEURON_ID_WIDTH = 7,
    parameter int NUM_NEURON      = 128,
    parameter int WORD_HOLD       = 2,
    parameter int CYC_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       host_wr_valid,
    output logic                       host_wr_ready,
    input  logic [FP_DATA_WIDTH-1:0]   host_wr_data,
    input  logic                       clear,
    input  logic                       start,
    input  logic [NEURON_ID_WIDTH-1:0] num_active,
    input  logic [CYC_WIDTH-1:0]       anneal_cycles,
    output logic [FP_DATA_WIDTH-1:0]   ins,
    output logic                       rd,
    input  logic [FP_DATA_WIDTH-1:0]   outs,
    input  logic                       readDone,
    output logic [FP_DATA_WIDTH-1:0]   rd_data,
    output logic                       rd_valid,
    output logic                       busy,
    output logic                       err
);
    localparam int DEPTH      = 4 * NUM_NEURON;
    localparam int ADDR_W     = $clog2(DEPTH);
    localparam int PTR_W      = $clog2(DEPTH + 1);      // must be able to hold DEPTH (full)
    localparam int HOLD_W     = (WORD_HOLD > 1) ? $clog2(WORD_HOLD) : 1;
    localparam int TMO_CYCLES = NUM_NEURON / 16 + 4;
    localparam int TMO_W      = $clog2(TMO_CYCLES);

    localparam logic [PTR_W-1:0]  DEPTH_P   = PTR_W'(DEPTH);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WORD_HOLD - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TMO_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND_N, S_SEND_BEGIN, S_STREAM, S_RUN, S_RD_REQ, S_RD_CAP
    } state_t;

    state_t                     state_q, state_d;
    logic [PTR_W-1:0]           ptr_q, ptr_d;
    logic [NEURON_ID_WIDTH-1:0] n_q, n_d;
    logic [CYC_WIDTH-1:0]       cyc_q, cyc_d;
    logic [HOLD_W-1:0]          hold_q, hold_d, hold_next;
    logic [ADDR_W-1:0]          idx_q, idx_d;
    logic [TMO_W-1:0]           tmo_q, tmo_d;
    logic [FP_DATA_WIDTH-1:0]   ins_d, rd_data_d;
    logic                       rd_d, rd_valid_d, err_d, wr_en;
    logic                       hold_done;
    logic [PTR_W-1:0]           req_words;
    logic [ADDR_W-1:0]          last_idx;

    logic [FP_DATA_WIDTH-1:0]   mem [DEPTH];

    // Ready depends on this cycle's start/clear so a write never races a
    // command; it is the one output that is not registered.
    assign host_wr_ready = !reset && (state_q == S_IDLE) && !start && !clear && (ptr_q < DEPTH_P);

    assign hold_done = (hold_q == HOLD_LAST);
    assign hold_next = hold_done ? '0 : hold_q + HOLD_W'(1);
    assign req_words = PTR_W'({num_active, 2'b00});
    assign last_idx  = ADDR_W'({n_q, 2'b00}) - ADDR_W'(1);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case statement can leave a latch behind.
        state_d    = state_q;
        ptr_d      = ptr_q;
        n_d        = n_q;
        cyc_d      = cyc_q;
        hold_d     = hold_q;
        idx_d      = idx_q;
        tmo_d      = tmo_q;
        rd_data_d  = rd_data;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        wr_en      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // clear outranks start; a start in the same cycle is dropped.
                if (clear) begin
                    ptr_d = '0;
                end else if (start) begin
                    if (num_active == '0 || ptr_q != req_words) begin
                        err_d = 1'b1;
                    end else begin
                        n_d     = num_active;
                        cyc_d   = anneal_cycles;
                        hold_d  = '0;
                        state_d = S_SEND_N;
                    end
                end else if (host_wr_valid && host_wr_ready) begin
                    wr_en = 1'b1;
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
            S_SEND_N: begin
                hold_d = hold_next;
                if (hold_done) state_d = S_SEND_BEGIN;
            end
            S_SEND_BEGIN: begin
                hold_d = hold_next;
                if (hold_done) begin
                    idx_d   = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                hold_d = hold_next;
                if (hold_done) begin
                    if (idx_q == last_idx) state_d = S_RUN;
                    else                   idx_d   = idx_q + ADDR_W'(1);
                end
            end
            S_RUN: begin
                // cyc_q was loaded at start; a count of 0 still gives one RUN cycle.
                if (cyc_q == '0) state_d = S_RD_REQ;
                else             cyc_d   = cyc_q - CYC_WIDTH'(1);
            end
            S_RD_REQ: begin
                tmo_d   = '0;
                state_d = S_RD_CAP;
            end
            S_RD_CAP: begin
                if (readDone) begin
                    rd_data_d  = outs;
                    rd_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    rd_data_d  = outs;
                    rd_valid_d = 1'b1;
                    tmo_d      = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state and registered, so ins/rd
        // line up with the state the sequencer is in. All ones only ever
        // appears in SEND_BEGIN or as streamed data.
        case (state_d)
            S_SEND_N:     ins_d = FP_DATA_WIDTH'(n_d);
            S_SEND_BEGIN: ins_d = '1;
            S_STREAM:     ins_d = mem[idx_d];
            default:      ins_d = '0;
        endcase
        rd_d = (state_d == S_RD_REQ);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            n_q      <= '0;
            cyc_q    <= '0;
            hold_q   <= '0;
            idx_q    <= '0;
            tmo_q    <= '0;
            ins      <= '0;
            rd       <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            n_q      <= n_d;
            cyc_q    <= cyc_d;
            hold_q   <= hold_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
            ins      <= ins_d;
            rd       <= rd_d;
            rd_data  <= rd_data_d;
            rd_valid <= rd_valid_d;
            busy     <= (state_d != S_IDLE);
            err      <= err_d;
        end
    end

    // NOTE: the buffer has no reset; resetting ptr_q is enough to discard it,
    // and leaving the array unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[ptr_q[ADDR_W-1:0]] <= host_wr_data;
    end

endmodule

// File: tb/tb_neuron_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_neuron_cfg_sequencer
//
// Self-checking bench for neuron_cfg_sequencer with default parameters.
// A per-cycle table covers a full N=2 sequence (stream, anneal, readout);
// hand-written sequences cover rejected starts, replay with readout timeout,
// buffer full/clear behaviour and reset in the middle of a stream.
// -----------------------------------------------------------------------------
module tb_neuron_cfg_sequencer;
    localparam int TMO_CYCLES = 128 / 16 + 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_wr_valid;
    logic        host_wr_ready;
    logic [15:0] host_wr_data;
    logic        clear;
    logic        start;
    logic [6:0]  num_active;
    logic [15:0] anneal_cycles;
    logic [15:0] ins;
    logic        rd;
    logic [15:0] outs;
    logic        readDone;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        err;

    int checks   = 0;
    int failures = 0;

    neuron_cfg_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .host_wr_valid (host_wr_valid),
        .host_wr_ready (host_wr_ready),
        .host_wr_data  (host_wr_data),
        .clear         (clear),
        .start         (start),
        .num_active    (num_active),
        .anneal_cycles (anneal_cycles),
        .ins           (ins),
        .rd            (rd),
        .outs          (outs),
        .readDone      (readDone),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [6:0]  n;
        logic [15:0] cyc;
        logic [15:0] outs;
        logic        rdone;
        logic [15:0] e_ins;
        logic        e_rd;
        logic        e_rv;
        logic [15:0] e_rdata;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input logic [15:0] d, input logic exp_ready);
        host_wr_valid = 1'b1;
        host_wr_data  = d;
        #1;
        check("wr_ready", host_wr_ready, exp_ready);
        tick();
        host_wr_valid = 1'b0;
    endtask

    function automatic void push(input logic s, input logic [6:0] n, input logic [15:0] cyc,
                                 input logic [15:0] o, input logic rdone, input logic [15:0] e_ins,
                                 input logic e_rd, input logic e_rv, input logic [15:0] e_rdata,
                                 input logic e_busy);
        vec_t v;
        v.start = s;     v.n = n;         v.cyc = cyc;   v.outs = o;       v.rdone = rdone;
        v.e_ins = e_ins; v.e_rd = e_rd;   v.e_rv = e_rv; v.e_rdata = e_rdata; v.e_busy = e_busy;
        tbl.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic prev_rv;

        // Non-start vectors drive junk on num_active/anneal_cycles to prove
        // those inputs are latched only at start.
        push(1, 7'd2, 16'd5, 16'h0, 0, 16'h0002, 0, 0, 16'h0, 1);   // SEND_N
        push(0, 7'd5, 16'd0, 16'h0, 0, 16'h0002, 0, 0, 16'h0, 1);
        push(0, 7'd5, 16'd0, 16'h0, 0, 16'hFFFF, 0, 0, 16'h0, 1);   // SEND_BEGIN
        push(0, 7'd5, 16'd0, 16'h0, 0, 16'hFFFF, 0, 0, 16'h0, 1);
        for (int w = 1; w <= 8; w++)                                 // STREAM
            for (int h = 0; h < 2; h++)
                push(0, 7'd5, 16'd0, 16'h0, 0, 16'h0100 + 16'(w), 0, 0, 16'h0, 1);
        for (int r = 0; r < 6; r++)                                  // RUN, anneal_cycles=5
            push(0, 7'd5, 16'd0, 16'h0, 0, 16'h0, 0, 0, 16'h0, 1);
        push(0, 7'd5, 16'd0, 16'h0,    0, 16'h0, 1, 0, 16'h0,    1); // RD_REQ
        push(0, 7'd5, 16'd0, 16'h0,    0, 16'h0, 0, 0, 16'h0,    1); // RD_CAP entered
        push(0, 7'd5, 16'd0, 16'hA5A5, 0, 16'h0, 0, 1, 16'hA5A5, 1);
        push(0, 7'd5, 16'd0, 16'h5A5A, 1, 16'h0, 0, 1, 16'h5A5A, 0); // readDone
        push(0, 7'd5, 16'd0, 16'h0,    0, 16'h0, 0, 0, 16'h5A5A, 0); // back in IDLE

        reset = 1'b1; host_wr_valid = 1'b0; host_wr_data = '0; clear = 1'b0; start = 1'b0;
        num_active = '0; anneal_cycles = '0; outs = '0; readDone = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_ins", ins, 16'h0);
        check("rst_rd", rd, 1'b0);
        check("rst_rd_data", rd_data, 16'h0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_ready", host_wr_ready, 1'b1);

        // Load the N=2 image.
        for (int i = 1; i <= 8; i++) wr_word(16'h0100 + 16'(i), 1'b1);

        // Full sequence: stream order/hold, rd timing, readout capture.
        foreach (tbl[i]) begin
            start = tbl[i].start; num_active = tbl[i].n; anneal_cycles = tbl[i].cyc;
            outs = tbl[i].outs; readDone = tbl[i].rdone;
            tick();
            check($sformatf("v%0d_ins", i), ins, tbl[i].e_ins);
            check($sformatf("v%0d_rd", i), rd, tbl[i].e_rd);
            check($sformatf("v%0d_rd_valid", i), rd_valid, tbl[i].e_rv);
            check($sformatf("v%0d_rd_data", i), rd_data, tbl[i].e_rdata);
            check($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
            check($sformatf("v%0d_err", i), err, 1'b0);
        end
        start = 1'b0; outs = '0; readDone = 1'b0;

        // Rejected starts: N mismatch with ptr=8, then N=0.
        num_active = 7'd3; start = 1'b1;
        tick(); start = 1'b0;
        check("bad_n_err", err, 1'b1);
        check("bad_n_busy", busy, 1'b0);
        tick();
        check("bad_n_err_pulse", err, 1'b0);
        check("bad_n_busy_after", busy, 1'b0);
        num_active = 7'd0; start = 1'b1;
        tick(); start = 1'b0;
        check("zero_n_err", err, 1'b1);
        check("zero_n_busy", busy, 1'b0);
        tick();

        // Replay the retained image, then let the readout time out.
        num_active = 7'd2; anneal_cycles = 16'd0; start = 1'b1; outs = 16'h1234;
        tick(); start = 1'b0;
        check("replay_n", ins, 16'h0002);
        tick(); tick(); tick(); tick();
        check("replay_first_word", ins, 16'h0101);
        k = 0;
        while (!rd && k < 200) begin tick(); k++; end
        check("replay_rd_seen", rd, 1'b1);
        k = 0;
        prev_rv = 1'b0;
        while (!err && k < 50) begin prev_rv = rd_valid; tick(); k++; end
        check("tmo_latency", k, TMO_CYCLES + 1);
        check("tmo_rv_before", prev_rv, 1'b1);
        check("tmo_rd_data", rd_data, 16'h1234);
        check("tmo_rv_stops", rd_valid, 1'b0);
        check("tmo_busy", busy, 1'b0);
        tick();
        check("tmo_err_pulse", err, 1'b0);
        outs = '0;

        // Buffer full and clear behaviour.
        clear = 1'b1; host_wr_valid = 1'b1; host_wr_data = 16'hDEAD;
        #1;
        check("clear_blocks_ready", host_wr_ready, 1'b0);
        tick();
        clear = 1'b0; host_wr_valid = 1'b0;
        for (int i = 0; i < 512; i++) wr_word(16'(i), 1'b1);
        wr_word(16'hBEEF, 1'b0);
        clear = 1'b1; host_wr_valid = 1'b1; host_wr_data = 16'hDEAD;
        tick();
        clear = 1'b0; host_wr_valid = 1'b0;
        #1;
        check("ready_after_clear", host_wr_ready, 1'b1);
        for (int i = 1; i <= 8; i++) wr_word(16'h0200 + 16'(i), 1'b1);
        num_active = 7'd2; anneal_cycles = 16'd3; start = 1'b1;
        tick(); start = 1'b0;
        check("post_clear_start_err", err, 1'b0);
        check("post_clear_busy", busy, 1'b1);
        tick(); tick(); tick(); tick();
        check("post_clear_word0", ins, 16'h0201);

        // Reset in the middle of STREAM.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_ins", ins, 16'h0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rd", rd, 1'b0);
        check("mid_rst_ready", host_wr_ready, 1'b1);
        num_active = 7'd2; start = 1'b1;
        tick(); start = 1'b0;
        check("mid_rst_ptr_zero_err", err, 1'b1);
        check("mid_rst_stays_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
